// File: rtl/data_mem_ctrl.sv
// Handshaked data memory for the multicycle MIPS core: byte/half/word access,
// sign/zero-extended loads, programmable wait states and alignment errors.

module data_mem_lane #(
  parameter int DEPTH = 256,
  parameter int IW    = 8,
  parameter int LANE  = 0
) (
  input  logic          CLK,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [1:0]    off,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [7:0]    rdata
);
  localparam logic [1:0] L = 2'(LANE);

  logic [7:0] mem [DEPTH] = '{default: 8'h00};
  logic       sel;
  logic [7:0] bsrc;

  // Store data is right-justified, so each lane picks its byte by position in the access.
  always_comb begin
    sel  = 1'b0;
    bsrc = wdata[7:0];
    case (size)
      2'd0: sel = (off == L);
      2'd1: begin
        sel  = (off[1] == L[1]);
        bsrc = L[0] ? wdata[15:8] : wdata[7:0];
      end
      2'd2: begin
        sel  = 1'b1;
        bsrc = wdata[8*LANE +: 8];
      end
      default: sel = 1'b0;
    endcase
  end

  always_ff @(posedge CLK)
    if (wr && sel) mem[idx] <= bsrc;

  assign rdata = mem[idx];
endmodule

module data_mem_ctrl #(
  parameter int DataDepth  = 256,
  parameter int AddrWidth  = 32,
  parameter int WaitStates = 1
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Req,
  input  logic                 W,
  input  logic [1:0]           Size,
  input  logic                 Unsigned,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [31:0]          W_data,
  output logic [31:0]          R_data,
  output logic                 Ack,
  output logic                 Err,
  output logic                 Busy
);
  localparam int         IW = $clog2(DataDepth);
  localparam logic [3:0] WS = 4'(WaitStates);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic                 w;
    logic [1:0]           size;
    logic                 uns;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
  } req_t;

  state_t               state, state_nxt;
  req_t                 cur;
  logic [3:0]           cnt;
  logic                 accept, illegal, complete;
  logic [3:0][7:0]      lane_rd;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [31:0]          load_v;
  logic                 unused_addr;

  assign accept   = (state != WAIT) && Req;
  assign complete = (state == WAIT) && (cnt == 4'd0);
  assign illegal  = (Size == 2'd3) || (Size == 2'd1 && Addr[0]) ||
                    (Size == 2'd2 && Addr[1:0] != 2'd0);

  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (!Req)         state_nxt = IDLE;
        else if (illegal) state_nxt = DONE;
        else              state_nxt = WAIT;
      end
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Ack  = (state == DONE);
    Busy = (state == WAIT);
  end

  // Memory is only touched at the completing edge, so a reset mid-WAIT drops the access.
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      cur    <= '0;
      cnt    <= 4'd0;
      Err    <= 1'b0;
      R_data <= 32'd0;
    end else begin
      if (accept) begin
        cur <= '{w: W, size: Size, uns: Unsigned, addr: Addr, wdata: W_data};
        cnt <= WS;
        Err <= illegal;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (complete && !cur.w) R_data <= load_v;
    end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    data_mem_lane #(.DEPTH(DataDepth), .IW(IW), .LANE(l)) u_lane (
      .CLK   (CLK),
      .wr    (complete && cur.w),
      .size  (cur.size),
      .off   (cur.addr[1:0]),
      .idx   (cur.addr[IW+1:2]),
      .wdata (cur.wdata),
      .rdata (lane_rd[l])
    );
  end

  always_comb begin
    byte_v = lane_rd[cur.addr[1:0]];
    half_v = cur.addr[1] ? {lane_rd[3], lane_rd[2]} : {lane_rd[1], lane_rd[0]};
    case (cur.size)
      2'd0:    load_v = {{24{!cur.uns && byte_v[7]}}, byte_v};
      2'd1:    load_v = {{16{!cur.uns && half_v[15]}}, half_v};
      default: load_v = lane_rd;
    endcase
  end

  // Upper address bits alias onto the same words.
  assign unused_addr = ^cur.addr[AddrWidth-1:IW+2];
endmodule
